// File: rtl/gpr_pkg.sv
// Shared definitions for the GPR read port: register-file geometry, the
// architectural zero register index and the skid-buffer occupancy encoding.
package gpr_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Occupancy of the output skid buffer (number of buffered operand pairs).
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/gpr_read_port_skid_buf.sv
// Two-entry valid/ready skid buffer carrying the registered operand pair.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   in_valid         a pair is pushed this cycle (already qualified by full)
//   in_data          pair being pushed
//   full             both entries occupied; upstream must not push
//   out_valid        head entry holds a pair
//   out_ready        consumer accepts the head this cycle
//   out_data         head pair (zero while empty)
module gpr_read_port_skid_buf #(
  parameter int PAYLOAD_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 full,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data
);
  import gpr_pkg::*;

  skid_state_e          state_q, state_d;
  logic [PAYLOAD_W-1:0] head_q, head_d;
  logic [PAYLOAD_W-1:0] tail_q, tail_d;
  logic                 take;

  assign out_valid = (state_q != SKID_EMPTY);
  assign full      = (state_q == SKID_TWO);
  assign take      = out_valid & out_ready;
  // Idle outputs read as zero so the port is quiet after reset.
  assign out_data  = out_valid ? head_q : '0;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      SKID_EMPTY: begin
        if (in_valid) begin
          head_d  = in_data;
          state_d = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (in_valid && !take) begin
          tail_d  = in_data;
          state_d = SKID_TWO;
        end else if (!in_valid && take) begin
          state_d = SKID_EMPTY;
        end else if (in_valid && take) begin
          head_d  = in_data;
        end
      end
      SKID_TWO: begin
        // Pushes are blocked while full, so only a drain can happen here.
        if (take) begin
          head_d  = tail_q;
          state_d = SKID_ONE;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SKID_EMPTY;
    end else begin
      state_q <= state_d;
    end
    head_q <= head_d;
    tail_q <= tail_d;
  end

endmodule

// File: rtl/gpr_read_port.sv
// Read side of the general-purpose register file. Mirrors the GPR write port
// into a local array, keeps a busy scoreboard of claimed destinations, stalls
// reads of busy sources and returns registered operand pairs through a
// two-entry skid buffer.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   reg_write_en/dest/data            snooped GPR write port
//   mark_en/mark_dest                 issue stage claims a destination
//   req_valid/req_ready               read request handshake
//   req_addr_1/req_addr_2             source indices
//   rsp_valid/rsp_ready               operand pair handshake
//   reg_read_data_1/reg_read_data_2   operand values
module gpr_read_port #(
  parameter int DATA_W = gpr_pkg::DATA_W,
  parameter int ADDR_W = gpr_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_write_en,
  input  logic [ADDR_W-1:0] reg_write_dest,
  input  logic [DATA_W-1:0] reg_write_data,
  input  logic              mark_en,
  input  logic [ADDR_W-1:0] mark_dest,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr_1,
  input  logic [ADDR_W-1:0] req_addr_2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] reg_read_data_1,
  output logic [DATA_W-1:0] reg_read_data_2
);
  import gpr_pkg::*;

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic              wr_en;
  logic              wr_hit_1, wr_hit_2;
  logic              hz;
  logic              skid_full;
  logic              accept;
  logic [DATA_W-1:0] rd_data_1, rd_data_2;

  function automatic logic [DATA_W-1:0] read_src(
    input logic [ADDR_W-1:0] addr,
    input logic              hit,
    input logic [DATA_W-1:0] arr_val
  );
    if (addr == ZERO_IDX) return '0;
    else if (hit)         return reg_write_data;
    else                  return arr_val;
  endfunction

  assign wr_en    = reg_write_en && (reg_write_dest != ZERO_IDX);
  assign wr_hit_1 = wr_en && (reg_write_dest == req_addr_1);
  assign wr_hit_2 = wr_en && (reg_write_dest == req_addr_2);

  // A write landing this cycle resolves the hazard because it is bypassed.
  assign hz        = (busy_q[req_addr_1] & ~wr_hit_1) | (busy_q[req_addr_2] & ~wr_hit_2);
  assign req_ready = ~rst & ~hz & ~skid_full;
  assign accept    = req_valid & req_ready;

  assign rd_data_1 = read_src(req_addr_1, wr_hit_1, mem_q[req_addr_1]);
  assign rd_data_2 = read_src(req_addr_2, wr_hit_2, mem_q[req_addr_2]);

  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[reg_write_dest] = 1'b0;
    // Applied after the clear so a same-cycle claim of the index survives.
    if (mark_en && (mark_dest != ZERO_IDX)) busy_d[mark_dest] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Mirror array: contents survive reset; index 0 is never written.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[reg_write_dest] <= reg_write_data;
  end

  gpr_read_port_skid_buf #(
    .PAYLOAD_W(2 * DATA_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (accept),
    .in_data  ({rd_data_1, rd_data_2}),
    .full     (skid_full),
    .out_valid(rsp_valid),
    .out_ready(rsp_ready),
    .out_data ({reg_read_data_1, reg_read_data_2})
  );

endmodule

// File: tb/tb_gpr_read_port.sv
module tb_gpr_read_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write_en;
  logic [4:0]  reg_write_dest;
  logic [31:0] reg_write_data;
  logic        mark_en;
  logic [4:0]  mark_dest;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_addr_1;
  logic [4:0]  req_addr_2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] reg_read_data_1;
  logic [31:0] reg_read_data_2;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: register contents, claimed registers, FIFO of pending pairs.
  logic [31:0] m_mem [32];
  bit          m_busy [32];
  logic [63:0] m_q [$];
  logic        ready_seen;

  always #5 clk = ~clk;

  gpr_read_port dut (
    .clk            (clk),
    .rst            (rst),
    .reg_write_en   (reg_write_en),
    .reg_write_dest (reg_write_dest),
    .reg_write_data (reg_write_data),
    .mark_en        (mark_en),
    .mark_dest      (mark_dest),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr_1     (req_addr_1),
    .req_addr_2     (req_addr_2),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .reg_read_data_1(reg_read_data_1),
    .reg_read_data_2(reg_read_data_2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wd, input logic [31:0] wdat,
                       input logic mk, input logic [4:0] md,
                       input logic rv, input logic [4:0] a1, input logic [4:0] a2,
                       input logic rr);
    reg_write_en = we; reg_write_dest = wd; reg_write_data = wdat;
    mark_en = mk; mark_dest = md;
    req_valid = rv; req_addr_1 = a1; req_addr_2 = a2;
    rsp_ready = rr;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (reg_write_en && reg_write_dest == a) return reg_write_data;
    return m_mem[a];
  endfunction

  function automatic bit m_blocked(input logic [4:0] a);
    return m_busy[a] && !(reg_write_en && a != 0 && reg_write_dest == a);
  endfunction

  // One clock: check req_ready against the model before the edge, advance the
  // model at the edge, then check the response side just after it.
  task automatic step();
    bit          exp_rdy, acc, tk;
    logic [63:0] pair;
    #3;
    exp_rdy = !rst && !m_blocked(req_addr_1) && !m_blocked(req_addr_2) && (m_q.size() < 2);
    ready_seen = req_ready;
    chk("req_ready", {63'd0, req_ready}, {63'd0, exp_rdy});
    acc  = req_valid && exp_rdy;
    tk   = (m_q.size() != 0) && rsp_ready;
    pair = {m_read(req_addr_1), m_read(req_addr_2)};
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      foreach (m_busy[i]) m_busy[i] = 0;
    end else begin
      if (tk) void'(m_q.pop_front());
      if (acc) m_q.push_back(pair);
      if (reg_write_en && reg_write_dest != 0) m_busy[reg_write_dest] = 0;
      if (mark_en && mark_dest != 0) m_busy[mark_dest] = 1;
    end
    if (reg_write_en && reg_write_dest != 0) m_mem[reg_write_dest] = reg_write_data;
    #1;
    chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, (m_q.size() != 0)});
    if (m_q.size() != 0)
      chk("rsp_data", {reg_read_data_1, reg_read_data_2}, m_q[0]);
  endtask

  initial begin
    foreach (m_mem[i]) m_mem[i] = 32'h0;
    foreach (m_busy[i]) m_busy[i] = 0;

    // Reset and preload every register with a random value.
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 1, 2, 1);
    step();
    chk("rst_ready", {63'd0, ready_seen}, 64'd0);
    step();
    chk("rst_outs", {rsp_valid, reg_read_data_1, reg_read_data_2}, 65'd0);
    rst = 1'b0;
    for (int i = 1; i < 32; i++) begin
      drive(1, 5'(i), $urandom, 0, 0, 0, 0, 0, 1);
      step();
    end

    // Plain write followed by a read.
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1); step();
    drive(0, 0, 0, 0, 0, 1, 5, 0, 1); step();
    chk("t1_data", {reg_read_data_1, reg_read_data_2}, {32'hDEADBEEF, 32'h0});
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); step();

    // Same-cycle write is bypassed into both sources.
    drive(1, 7, 32'h12345678, 0, 0, 1, 7, 7, 1); step();
    chk("t2_bypass", {reg_read_data_1, reg_read_data_2}, {32'h12345678, 32'h12345678});
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); step();

    // Busy source stalls until its write arrives.
    drive(0, 0, 0, 1, 3, 0, 0, 0, 1); step();
    drive(0, 0, 0, 0, 0, 1, 3, 1, 1); step();
    chk("t3_stall", {63'd0, ready_seen}, 64'd0);
    drive(1, 3, 32'h55, 0, 0, 1, 3, 1, 1); step();
    chk("t3_accept", {63'd0, ready_seen}, 64'd1);
    chk("t3_data1", {32'd0, reg_read_data_1}, 64'h55);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); step();

    // Back-pressure fills the skid buffer, then drains in order.
    drive(0, 0, 0, 0, 0, 1, 5, 7, 0); step();
    drive(0, 0, 0, 0, 0, 1, 7, 5, 0); step();
    drive(0, 0, 0, 0, 0, 1, 3, 3, 0); step();
    chk("t4_full", {63'd0, ready_seen}, 64'd0);
    chk("t4_stable", {reg_read_data_1, reg_read_data_2}, {32'hDEADBEEF, 32'h12345678});
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    chk("t4_second", {reg_read_data_1, reg_read_data_2}, {32'h12345678, 32'hDEADBEEF});
    step();
    chk("t4_empty", {63'd0, rsp_valid}, 64'd0);

    // x0 ignores writes and claims.
    drive(1, 0, 32'hFFFFFFFF, 1, 0, 1, 0, 0, 1); step();
    chk("t5_ready", {63'd0, ready_seen}, 64'd1);
    chk("t5_zero", {31'd0, rsp_valid, reg_read_data_1, reg_read_data_2}, {31'd0, 1'b1, 64'd0});
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); step();

    // Reset while full with x9 busy.
    drive(0, 0, 0, 1, 9, 1, 1, 2, 0); step();
    drive(0, 0, 0, 0, 0, 1, 2, 1, 0); step();
    chk("t6_two", {63'd0, rsp_valid}, 64'd1);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    chk("t6_rst_outs", {rsp_valid, reg_read_data_1, reg_read_data_2}, 65'd0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 1, 9, 9, 1); step();
    chk("t6_ready", {63'd0, ready_seen}, 64'd1);
    chk("t6_data", {reg_read_data_1, reg_read_data_2}, {m_mem[9], m_mem[9]});

    // Random traffic over a narrow index range to provoke hazards and bypasses.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom_range(0, 4) < 3);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
